// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS datapath: Moore control strobes
// per state/opcode, data-memory wait states with timeout, retired-instruction count.
module mips_multicycle_ctrl #(
    parameter int OPCODE_WIDTH = 6,
    parameter int CNT_WIDTH    = 32,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                    cu_clk,
    input  logic                    cu_rst,
    input  logic                    cu_i_en,
    input  logic [OPCODE_WIDTH-1:0] cu_i_opcode,
    input  logic                    cu_i_mem_ready,
    output logic                    cu_o_ce,
    output logic                    cu_o_RegDst,
    output logic                    cu_o_RegWrite,
    output logic                    cu_o_ALUSrc,
    output logic                    cu_o_Branch,
    output logic                    cu_o_MemRead,
    output logic                    cu_o_MemWrite,
    output logic                    cu_o_MemtoReg,
    output logic [2:0]              cu_o_state,
    output logic                    cu_o_illegal,
    output logic                    cu_o_timeout,
    output logic [CNT_WIDTH-1:0]    cu_o_retired
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'h00);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'h08);
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'h23);
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'h2B);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'h04);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5
    } state_t;

    state_t                  state_reg, state_next;
    logic [OPCODE_WIDTH-1:0] opcode_reg, opcode_next;
    logic [WAIT_W-1:0]       wait_reg, wait_next;
    logic [CNT_WIDTH-1:0]    retired_reg;
    logic                    retire;
    logic                    illegal_reg, illegal_next;
    logic                    timeout_reg, timeout_next;
    state_t                  done_state;

    function automatic logic is_supported(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ);
    endfunction

    always_ff @(posedge cu_clk or posedge cu_rst) begin
        if (cu_rst) begin
            state_reg   <= S_IDLE;
            opcode_reg  <= '0;
            wait_reg    <= '0;
            retired_reg <= '0;
            illegal_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            opcode_reg  <= opcode_next;
            wait_reg    <= wait_next;
            retired_reg <= retired_reg + CNT_WIDTH'(retire);
            illegal_reg <= illegal_next;
            timeout_reg <= timeout_next;
        end
    end

    // An instruction always runs to completion; enable only decides where we go afterwards.
    assign done_state = cu_i_en ? S_FETCH : S_IDLE;

    always_comb begin
        state_next   = state_reg;
        opcode_next  = opcode_reg;
        wait_next    = '0;
        retire       = 1'b0;
        illegal_next = 1'b0;
        timeout_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (cu_i_en)
                    state_next = S_FETCH;
            end
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                opcode_next = cu_i_opcode;
                if (is_supported(cu_i_opcode)) begin
                    state_next = S_EXECUTE;
                end else begin
                    illegal_next = 1'b1;
                    state_next   = done_state;
                end
            end
            S_EXECUTE: begin
                if (opcode_reg == OP_LW || opcode_reg == OP_SW) begin
                    state_next = S_MEMORY;
                end else if (opcode_reg == OP_BEQ) begin
                    retire     = 1'b1;
                    state_next = done_state;
                end else begin
                    state_next = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (cu_i_mem_ready) begin
                    if (opcode_reg == OP_LW) begin
                        state_next = S_WRITEBACK;
                    end else begin
                        retire     = 1'b1;
                        state_next = done_state;
                    end
                end else if (wait_reg == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    // This wait cycle brings the count to MEM_TIMEOUT: abandon the access.
                    timeout_next = 1'b1;
                    state_next   = done_state;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            S_WRITEBACK: begin
                retire     = 1'b1;
                state_next = done_state;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cu_o_ce       = 1'b0;
        cu_o_RegDst   = 1'b0;
        cu_o_RegWrite = 1'b0;
        cu_o_ALUSrc   = 1'b0;
        cu_o_Branch   = 1'b0;
        cu_o_MemRead  = 1'b0;
        cu_o_MemWrite = 1'b0;
        cu_o_MemtoReg = 1'b0;
        case (state_reg)
            S_FETCH: cu_o_ce = 1'b1;
            S_EXECUTE: begin
                cu_o_RegDst = (opcode_reg == OP_RTYPE);
                cu_o_ALUSrc = (opcode_reg == OP_ADDI) || (opcode_reg == OP_LW) ||
                              (opcode_reg == OP_SW);
                cu_o_Branch = (opcode_reg == OP_BEQ);
            end
            S_MEMORY: begin
                cu_o_MemRead  = (opcode_reg == OP_LW);
                cu_o_MemWrite = (opcode_reg == OP_SW);
            end
            S_WRITEBACK: begin
                cu_o_RegWrite = 1'b1;
                cu_o_MemtoReg = (opcode_reg == OP_LW);
                cu_o_RegDst   = (opcode_reg == OP_RTYPE);
            end
            default: ;
        endcase
    end

    assign cu_o_state   = state_reg;
    assign cu_o_illegal = illegal_reg;
    assign cu_o_timeout = timeout_reg;
    assign cu_o_retired = retired_reg;

endmodule
